// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU-side memory responder.
package mem_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory-port handshake: request/address/data out of the CPU, response back.
interface mem_responder_if #(
    parameter int REG_WIDTH = 16
);
    logic                 req;
    logic                 we;
    logic [REG_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0] wdata;
    logic [REG_WIDTH-1:0] rdata;
    logic                 ready;
    logic                 err;
    logic                 busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/mem_array.sv
// Word-addressed storage: one write port, one synchronous read port, contents never reset.
module mem_array #(
    parameter int REG_WIDTH = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [REG_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [REG_WIDTH-1:0] rd_data
);

    logic [REG_WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed wait states and an IDLE-only preload port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int REG_WIDTH   = 16,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_responder_if.slave       bus,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [REG_WIDTH-1:0] load_data
);

    mem_state_t           state;
    mem_state_t           state_nxt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 we_q;
    logic [REG_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0] wdata_q;

    logic                 accept;
    logic                 in_range;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [REG_WIDTH-1:0] wr_data;
    logic [REG_WIDTH-1:0] rd_data;

    // The loader owns the idle cycle it strobes; the CPU request waits one cycle.
    assign accept   = (state == IDLE) && !load_en && bus.req;
    assign in_range = (addr_q[REG_WIDTH-1:ADDR_BITS] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_W'(WAIT_STATES);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Request fields are frozen at acceptance so bus changes mid-flight are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= WAIT_W'(1)) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = load_addr;
        wr_data = load_data;
        if (state == IDLE && load_en) begin
            wr_en = 1'b1;
        end else if (state == ACCESS && we_q && in_range) begin
            wr_en   = 1'b1;
            wr_addr = addr_q[ADDR_BITS-1:0];
            wr_data = wdata_q;
        end
    end

    mem_array #(
        .REG_WIDTH (REG_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (addr_q[ADDR_BITS-1:0]),
        .rd_data (rd_data)
    );

    // Read data is captured on the ACCESS edge and presented during RESP.
    always_comb begin
        bus.ready = (state == RESP);
        bus.err   = (state == RESP) && !in_range;
        bus.busy  = (state != IDLE);
        bus.rdata = '0;
        if (state == RESP && in_range && !we_q) begin
            bus.rdata = rd_data;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_mem_responder;

    logic clk;
    logic rst_n;

    logic        ld_en_a, ld_en_b;
    logic [7:0]  ld_addr_a, ld_addr_b;
    logic [15:0] ld_data_a, ld_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder_if #(.REG_WIDTH(16)) bus_a ();
    mem_responder_if #(.REG_WIDTH(16)) bus_b ();

    mem_responder #(.REG_WIDTH(16), .ADDR_BITS(8), .WAIT_STATES(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a),
        .load_en   (ld_en_a),
        .load_addr (ld_addr_a),
        .load_data (ld_data_a)
    );

    mem_responder #(.REG_WIDTH(16), .ADDR_BITS(8), .WAIT_STATES(0)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b),
        .load_en   (ld_en_b),
        .load_addr (ld_addr_b),
        .load_data (ld_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input int sel, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        if (sel == 0) begin
            bus_a.req = r; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
        end else begin
            bus_b.req = r; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
        end
    endtask

    task automatic set_ld(input int sel, input logic en, input logic [7:0] a, input logic [15:0] d);
        if (sel == 0) begin
            ld_en_a = en; ld_addr_a = a; ld_data_a = d;
        end else begin
            ld_en_b = en; ld_addr_b = a; ld_data_b = d;
        end
    endtask

    function automatic logic [15:0] get_rdata(input int sel);
        return (sel == 0) ? bus_a.rdata : bus_b.rdata;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus_a.ready : bus_b.ready;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus_a.err : bus_b.err;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    task automatic loader_write(input int sel, input logic [7:0] a, input logic [15:0] d);
        set_ld(sel, 1'b1, a, d);
        @(posedge clk); #1;
        set_ld(sel, 1'b0, 8'h00, 16'h0000);
    endtask

    // Drives one request; lat counts rising edges from the accepting edge (edge 1) to ready.
    task automatic do_req(input int sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                          input int lat, input logic [15:0] exp_rdata, input logic exp_err,
                          input logic drop_early, input logic busy_ld,
                          input logic [7:0] bl_addr, input logic [15:0] bl_data, input string tag);
        set_bus(sel, 1'b1, w, a, d);
        for (int k = 1; k <= lat + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                set_ld(sel, 1'b0, 8'h00, 16'h0000);
                if (drop_early) set_bus(sel, 1'b0, ~w, ~a, ~d);
                if (busy_ld) begin
                    check({tag, "/busy"}, 16'(get_busy(sel)), 16'h1);
                    set_ld(sel, 1'b1, bl_addr, bl_data);
                end
            end else if (k == 2 && busy_ld) begin
                set_ld(sel, 1'b0, 8'h00, 16'h0000);
            end
            if (k < lat) begin
                check({tag, "/early_ready"}, 16'(get_ready(sel)), 16'h0);
            end else if (k == lat) begin
                check({tag, "/ready"}, 16'(get_ready(sel)), 16'h1);
                check({tag, "/rdata"}, get_rdata(sel), exp_rdata);
                check({tag, "/err"}, 16'(get_err(sel)), 16'(exp_err));
                set_bus(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end else begin
                check({tag, "/ready_pulse_end"}, 16'(get_ready(sel)), 16'h0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_bus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_bus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_ld(0, 1'b0, 8'h00, 16'h0000);
        set_ld(1, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int s = 0; s < 2; s++) begin
            check("reset/ready", 16'(get_ready(s)), 16'h0);
            check("reset/err",   16'(get_err(s)),   16'h0);
            check("reset/busy",  16'(get_busy(s)),  16'h0);
            check("reset/rdata", get_rdata(s),      16'h0000);
        end

        loader_write(0, 8'h05, 16'h1234);
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "ldrd_a");

        do_req(0, 1'b1, 16'h0020, 16'hBEEF, 3, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "st_a");
        do_req(0, 1'b0, 16'h0020, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "strd_a");

        do_req(1, 1'b1, 16'h0020, 16'hBEEF, 2, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "st_b");
        do_req(1, 1'b0, 16'h0020, 16'h0000, 2, 16'hBEEF, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, "strd_b_drop");

        do_req(0, 1'b1, 16'h0105, 16'hAAAA, 3, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, "oor_st");
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "oor_after");
        do_req(0, 1'b0, 16'h0300, 16'h0000, 3, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, "oor_ld");

        // Loader and request in the same idle cycle: the write lands, acceptance slips one cycle.
        set_ld(0, 1'b1, 8'h07, 16'h7777);
        do_req(0, 1'b0, 16'h0007, 16'h0000, 4, 16'h7777, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "ld_and_req");

        loader_write(0, 8'h09, 16'h0009);
        do_req(0, 1'b0, 16'h0009, 16'h0000, 3, 16'h0009, 1'b0, 1'b0, 1'b1, 8'h05, 16'hDEAD, "busy_ld");
        do_req(0, 1'b0, 16'h0005, 16'h0000, 3, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "busy_ld_rd");

        // Reset while a store sits in WAIT must discard it without a response.
        set_bus(0, 1'b1, 1'b1, 16'h0020, 16'hCAFE);
        @(posedge clk); #1;
        check("rst_mid/busy_before", 16'(get_busy(0)), 16'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid/busy_after", 16'(get_busy(0)), 16'h0);
        set_bus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_mid/no_ready", 16'(get_ready(0)), 16'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1'b0, 16'h0020, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "rst_mid_rd");
        do_req(1, 1'b0, 16'h0020, 16'h0000, 2, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "rst_keep_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
